regfile_mp: RTL and testbench

- Parametrised successor to the single-write / dual-read pipeline register file used by the rv32 core.
- Generalised in data width, register count and number of read ports.
- Adds:
  - a hardwired zero register
  - same-cycle write-to-read bypass
  - a sequential zeroing engine run after reset or on request, with a ready flag
- Sits between decode (read ports) and writeback (write port) of the 3-stage pipeline.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_mp_if.sv | 44 ++++
 rtl/regfile_rdport.sv | 47 ++++
 rtl/regfile_mp.sv | 98 +++++++++
 tb/tb_regfile_mp.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_mp shared types and defaults.
// Sweep state encoding and parameter defaults.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp port bundle.
// master drives requests, slave is the register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
);

  localparam int AW = $clog2(NREGS);

  logic                clr_req;
  logic                ready;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;

  modport master (
    output clr_req,
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_en,
    output rd_addr,
    input  ready,
    input  rd_data
  );

  modport slave (
    input  clr_req,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_en,
    input  rd_addr,
    output ready,
    output rd_data
  );

endinterface

// File: rtl/regfile_rdport.sv
// One registered read port of regfile_mp.
// Zero-masking first, then write-first bypass, then array.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  state_e          state,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic            wr_ok,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [XLEN-1:0] arr_val,
  output logic [XLEN-1:0] data
);

  localparam logic [AW:0]   NR = (AW+1)'(NREGS);
  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  logic zero;
  logic byp;

  assign zero = (state == INIT)
             || (addr == ZA)
             || ({1'b0, addr} >= NR);

  assign byp = !zero && wr_ok
            && (wr_addr == addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      unique case (1'b1)
        zero:    data <= '0;
        byp:     data <= wr_data;
        default: data <= arr_val;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0, bypass and
// a zeroing sweep after reset or on clr_req.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  localparam int            AW = $clog2(NREGS);
  localparam logic [AW:0]   NR = (AW+1)'(NREGS);
  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  state_e                   state;
  logic [AW:0]              ptr;
  logic                     ready_q;
  logic                     sweep;
  logic                     wr_ok;
  logic [XLEN-1:0]          regs [NREGS];
  logic [NRD-1:0][XLEN-1:0] rd_q;

  // ptr==NR is the extra settle cycle before RUN
  assign sweep = (state == INIT)
              && (ptr != NR);

  assign wr_ok = (state == RUN)
              && bus.wr_en
              && (bus.wr_addr != ZA)
              && ({1'b0, bus.wr_addr} < NR);

  assign bus.ready   = ready_q;
  assign bus.rd_data = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      ptr     <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (ptr == NR) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        RUN: begin
          if (bus.clr_req) begin
            state   <= INIT;
            ptr     <= '0;
            ready_q <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sweep) begin
      regs[ptr[AW-1:0]] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] av;

    assign a  = bus.rd_addr[i*AW +: AW];
    assign av = ({1'b0, a} < NR) ? regs[a] : '0;

    regfile_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .state   (state),
      .en      (bus.rd_en[i]),
      .addr    (a),
      .wr_ok   (wr_ok),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .arr_val (av),
      .data    (rd_q[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 32x2 and a 24x3
// instance, read data checked through a scoreboard.
module tb_regfile_mp;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int ncmp = 0;
  int nmis = 0;

  sb_t         qa[$];
  sb_t         qb[$];
  logic [31:0] last_a [2];
  logic [31:0] last_b [3];

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ia ();
  regfile_mp_if #(.XLEN(32), .NREGS(24), .NRD(3)) ib ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) u_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (ia.slave)
  );

  regfile_mp #(.XLEN(32), .NREGS(24), .NRD(3)) u_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (ib.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(bit we, int wa, logic [31:0] wd,
                       logic [1:0] re, int r0, int r1, bit clr);
    ia.wr_en   = we;
    ia.wr_addr = 5'(wa);
    ia.wr_data = wd;
    ia.rd_en   = re;
    ia.rd_addr = {5'(r1), 5'(r0)};
    ia.clr_req = clr;
  endtask

  task automatic drv_b(bit we, int wa, logic [31:0] wd,
                       logic [2:0] re, int r0, int r1, int r2, bit clr);
    ib.wr_en   = we;
    ib.wr_addr = 5'(wa);
    ib.wr_data = wd;
    ib.rd_en   = re;
    ib.rd_addr = {5'(r2), 5'(r1), 5'(r0)};
    ib.clr_req = clr;
  endtask

  // disabled ports are expected to hold their last value
  task automatic exp_a(string tag, logic [31:0] e0, logic [31:0] e1);
    logic [31:0] e [2];
    sb_t s;
    e[0] = e0;
    e[1] = e1;
    for (int p = 0; p < 2; p++) begin
      if (ia.rd_en[p]) last_a[p] = e[p];
      s.tag  = $sformatf("%s_p%0d", tag, p);
      s.port = p;
      s.exp  = last_a[p];
      qa.push_back(s);
    end
  endtask

  task automatic exp_b(string tag, logic [31:0] e0,
                       logic [31:0] e1, logic [31:0] e2);
    logic [31:0] e [3];
    sb_t s;
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    for (int p = 0; p < 3; p++) begin
      if (ib.rd_en[p]) last_b[p] = e[p];
      s.tag  = $sformatf("%s_p%0d", tag, p);
      s.port = p;
      s.exp  = last_b[p];
      qb.push_back(s);
    end
  endtask

  task automatic tick();
    sb_t s;
    @(posedge clk);
    #1;
    while (qa.size() > 0) begin
      s = qa.pop_front();
      chk(s.tag, 96'(ia.rd_data[s.port*32 +: 32]), 96'(s.exp));
    end
    while (qb.size() > 0) begin
      s = qb.pop_front();
      chk(s.tag, 96'(ib.rd_data[s.port*32 +: 32]), 96'(s.exp));
    end
  endtask

  initial begin
    last_a = '{default: '0};
    last_b = '{default: '0};
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    drv_a(0, 0, 0, 2'b00, 0, 0, 0);
    drv_b(0, 0, 0, 3'b000, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy_a", 96'(ia.ready), 96'(0));
    chk("rst_rd_a", 96'(ia.rd_data), 96'(0));
    chk("rst_rdy_b", 96'(ib.ready), 96'(0));
    chk("rst_rd_b", 96'(ib.rd_data), 96'(0));

    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      chk($sformatf("swp_rdy_a_%0d", k), 96'(ia.ready), 96'(k == 33));
      chk($sformatf("swp_rdy_b_%0d", k), 96'(ib.ready), 96'(k >= 25));
    end

    for (int a = 0; a < 32; a++) begin
      drv_a(0, 0, 0, 2'b11, a, 31 - a, 0);
      exp_a("init_zero", 0, 0);
      tick();
    end

    drv_a(1, 5, 32'hDEADBEEF, 2'b00, 0, 0, 0);
    exp_a("wr_x5_hold", 0, 0);
    tick();
    drv_a(0, 0, 0, 2'b11, 5, 5, 0);
    exp_a("rd_x5", 32'hDEADBEEF, 32'hDEADBEEF);
    tick();

    drv_a(1, 7, 32'h12345678, 2'b11, 7, 6, 0);
    exp_a("byp_x7", 32'h12345678, 0);
    tick();
    drv_a(0, 0, 0, 2'b10, 5, 7, 0);
    exp_a("rd_x7_p1", 0, 32'h12345678);
    tick();

    drv_a(1, 0, 32'hFFFFFFFF, 2'b00, 0, 0, 0);
    exp_a("wr_x0_hold", 0, 0);
    tick();
    drv_a(0, 0, 0, 2'b11, 0, 0, 0);
    exp_a("rd_x0", 0, 0);
    tick();
    drv_a(1, 0, 32'hFFFFFFFF, 2'b11, 0, 5, 0);
    exp_a("byp_x0", 0, 32'hDEADBEEF);
    tick();

    for (int i = 1; i < 32; i++) begin
      drv_a(1, i, 32'(i), 2'b00, 0, 0, 0);
      tick();
    end
    drv_a(0, 0, 0, 2'b11, 31, 1, 0);
    exp_a("fill_rd", 32'd31, 32'd1);
    tick();

    drv_a(0, 0, 0, 2'b00, 0, 0, 1);
    exp_a("clr_hold", 0, 0);
    tick();
    chk("clr_rdy0", 96'(ia.ready), 96'(0));
    for (int k = 1; k <= 33; k++) begin
      drv_a(1, k % 31 + 1, 32'hA5A5A5A5, 2'b11, 3, 9, k == 20);
      exp_a("clr_swp_rd", 0, 0);
      tick();
      chk($sformatf("clr_rdy_%0d", k), 96'(ia.ready), 96'(k == 33));
    end
    for (int a = 0; a < 32; a++) begin
      drv_a(0, 0, 0, 2'b11, a, 31 - a, 0);
      exp_a("post_clr", 0, 0);
      tick();
    end
    drv_a(0, 0, 0, 2'b00, 0, 0, 0);

    drv_b(1, 30, 32'h30303030, 3'b111, 30, 23, 30, 0);
    exp_b("b_oob", 0, 0, 0);
    tick();
    drv_b(1, 23, 32'h23, 3'b000, 0, 0, 0, 0);
    exp_b("b_wr23_hold", 0, 0, 0);
    tick();
    drv_b(0, 0, 0, 3'b111, 23, 23, 23, 0);
    exp_b("b_rd23", 32'h23, 32'h23, 32'h23);
    tick();
    drv_b(1, 10, 32'hCAFE, 3'b111, 10, 10, 10, 0);
    exp_b("b_byp10", 32'hCAFE, 32'hCAFE, 32'hCAFE);
    tick();
    drv_b(0, 0, 0, 3'b111, 30, 0, 10, 0);
    exp_b("b_rd_mix", 0, 0, 32'hCAFE);
    tick();

    drv_b(0, 0, 0, 3'b000, 0, 0, 0, 1);
    exp_b("b_clr_hold", 0, 0, 0);
    tick();
    drv_b(0, 0, 0, 3'b000, 0, 0, 0, 0);
    chk("b_clr_rdy0", 96'(ib.ready), 96'(0));
    repeat (10) tick();
    rst_b = 1'b0;
    #1;
    chk("b_mid_rst_rdy", 96'(ib.ready), 96'(0));
    chk("b_mid_rst_rd", 96'(ib.rd_data), 96'(0));
    last_b = '{default: '0};
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk($sformatf("b_rswp_rdy_%0d", k), 96'(ib.ready), 96'(k == 25));
    end
    drv_b(0, 0, 0, 3'b111, 23, 10, 5, 0);
    exp_b("b_post_rst", 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
